rxll_fis_dispatch: RTL and testbench

- Sits directly downstream of the receive link-layer FIFO, on its read clock.
- Pulls complete FIS frames out of the first-word-fall-through FIFO, decodes the FIS type from dword 0 and routes the frame.
- Data FIS payload goes to the DMA write stream (valid/ready). Register-class FIS are captured into a 7-dword buffer for the command layer.
- Unknown, erroneous or oversize frames are drained to EOF and flagged.

---
 rtl/ahci_fis_pkg.sv | 38 +++
 rtl/rxll_reg_buf.sv | 34 +++
 rtl/rxll_fis_dispatch.sv | 182 ++++++++++++++++++
 tb/tb_rxll_fis_dispatch.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahci_fis_pkg.sv
// Shared FIS type constants, link-layer sideband bit positions and the
// receive-dispatch state/error encodings.
package ahci_fis_pkg;

    localparam logic [7:0] FIS_REG_D2H   = 8'h34;
    localparam logic [7:0] FIS_DMA_ACT   = 8'h39;
    localparam logic [7:0] FIS_DMA_SETUP = 8'h41;
    localparam logic [7:0] FIS_DATA      = 8'h46;
    localparam logic [7:0] FIS_BIST      = 8'h58;
    localparam logic [7:0] FIS_PIO_SETUP = 8'h5F;
    localparam logic [7:0] FIS_SDB       = 8'hA1;

    localparam int LL_EOF = 34;
    localparam int LL_ERR = 35;

    typedef enum logic [1:0] {
        ERR_UNKNOWN  = 2'd0,
        ERR_LINK     = 2'd1,
        ERR_OVERSIZE = 2'd2
    } rx_err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_REG,
        ST_DROP
    } rx_state_e;

    function automatic logic is_reg_fis(input logic [7:0] t);
        case (t)
            FIS_REG_D2H, FIS_DMA_ACT, FIS_DMA_SETUP,
            FIS_BIST, FIS_PIO_SETUP, FIS_SDB: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rxll_reg_buf.sv
// Register-FIS capture buffer: sequential write at an internal dword counter,
// combinational read by index.
module rxll_reg_buf #(
    parameter int DEPTH = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [2:0]  raddr,
    output logic [2:0]  cnt,
    output logic [31:0] rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (we)
            cnt <= cnt + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (we && cnt < 3'(DEPTH))
            mem[cnt] <= wdata;
    end

    assign rdata = (raddr < 3'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/rxll_fis_dispatch.sv
// Receive FIS dispatcher: routes frames from the link FIFO to the DMA stream,
// the register-FIS buffer, or drains them. Define RXLL_DISPATCH_STATS_EN for counters.
module rxll_fis_dispatch
    import ahci_fis_pkg::*;
#(
    parameter int         C_REG_DEPTH = 7,
    parameter logic [7:0] C_FIS_DATA  = FIS_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] fifo_do,
    input  logic        fifo_empty,
    input  logic        fifo_eof_rdy,
    output logic        fifo_rd_en,
    output logic [31:0] dma_data,
    output logic        dma_valid,
    output logic        dma_last,
    input  logic        dma_ready,
    output logic        reg_fis_vld,
    output logic [7:0]  reg_fis_type,
    output logic [2:0]  reg_fis_len,
    input  logic [2:0]  reg_addr,
    output logic [31:0] reg_dout,
    input  logic        reg_fis_ack,
    output logic        rx_err,
    output logic [1:0]  rx_err_code,
    output logic        busy
`ifdef RXLL_DISPATCH_STATS_EN
    ,
    output logic [15:0] stat_frames,
    output logic [15:0] stat_drops,
    output logic [31:0] stat_data_dw
`endif
);

    rx_state_e   state;
    rx_err_e     drop_code;
    logic [7:0]  hdr_type;
    logic [2:0]  cnt;
    logic        d_eof, d_err;
    logic [7:0]  fis_t;
    logic        unused_sb;

    assign d_eof     = fifo_do[LL_EOF];
    assign d_err     = fifo_do[LL_ERR];
    assign fis_t     = fifo_do[7:0];
    assign unused_sb = ^fifo_do[33:32];

    // The header is only popped here for data frames; register and drop
    // paths pop it in their own state so it gets captured/counted there.
    always_comb begin
        fifo_rd_en = 1'b0;
        case (state)
            ST_HDR:          fifo_rd_en = !fifo_empty && !d_err && fis_t == C_FIS_DATA;
            ST_DATA:         fifo_rd_en = !fifo_empty && dma_ready;
            ST_REG, ST_DROP: fifo_rd_en = !fifo_empty;
            default:         fifo_rd_en = 1'b0;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign dma_valid = (state == ST_DATA) && !fifo_empty;
    assign dma_data  = (state == ST_DATA) ? fifo_do[31:0] : '0;
    assign dma_last  = dma_valid && (d_eof || d_err);

    rxll_reg_buf #(.DEPTH(C_REG_DEPTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == ST_HDR),
        .we    (state == ST_REG && fifo_rd_en),
        .wdata (fifo_do[31:0]),
        .raddr (reg_addr),
        .cnt   (cnt),
        .rdata (reg_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            drop_code    <= ERR_UNKNOWN;
            hdr_type     <= '0;
            rx_err       <= 1'b0;
            rx_err_code  <= '0;
            reg_fis_vld  <= 1'b0;
            reg_fis_type <= '0;
            reg_fis_len  <= '0;
        end else begin
            rx_err <= 1'b0;
            if (reg_fis_ack)
                reg_fis_vld <= 1'b0;
            case (state)
                ST_IDLE: if (fifo_eof_rdy && !fifo_empty) state <= ST_HDR;
                ST_HDR: if (!fifo_empty) begin
                    if (d_err) begin
                        drop_code <= ERR_LINK;
                        state     <= ST_DROP;
                    end else if (fis_t == C_FIS_DATA) begin
                        if (d_eof) begin
                            rx_err      <= 1'b1;
                            rx_err_code <= ERR_UNKNOWN;
                            state       <= ST_IDLE;
                        end else
                            state <= ST_DATA;
                    end else if (is_reg_fis(fis_t)) begin
                        // Buffer still owned by the consumer: hold the frame.
                        if (!reg_fis_vld) begin
                            hdr_type <= fis_t;
                            state    <= ST_REG;
                        end
                    end else begin
                        drop_code <= ERR_UNKNOWN;
                        state     <= ST_DROP;
                    end
                end
                ST_DATA: if (fifo_rd_en) begin
                    if (d_err) begin
                        rx_err      <= 1'b1;
                        rx_err_code <= ERR_LINK;
                        state       <= ST_IDLE;
                    end else if (d_eof)
                        state <= ST_IDLE;
                end
                ST_REG: if (fifo_rd_en) begin
                    if (d_err) begin
                        if (d_eof) begin
                            rx_err      <= 1'b1;
                            rx_err_code <= ERR_LINK;
                            state       <= ST_IDLE;
                        end else begin
                            drop_code <= ERR_LINK;
                            state     <= ST_DROP;
                        end
                    end else if (d_eof) begin
                        reg_fis_vld  <= 1'b1;
                        reg_fis_len  <= cnt + 3'd1;
                        reg_fis_type <= hdr_type;
                        state        <= ST_IDLE;
                    end else if (cnt == 3'(C_REG_DEPTH - 1)) begin
                        drop_code <= ERR_OVERSIZE;
                        state     <= ST_DROP;
                    end
                end
                ST_DROP: if (fifo_rd_en && d_eof) begin
                    rx_err      <= 1'b1;
                    rx_err_code <= drop_code;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RXLL_DISPATCH_STATS_EN
    logic frame_done;

    always_comb begin
        frame_done = 1'b0;
        case (state)
            ST_HDR:          frame_done = fifo_rd_en && d_eof;
            ST_DATA:         frame_done = fifo_rd_en && (d_eof || d_err);
            ST_REG, ST_DROP: frame_done = fifo_rd_en && d_eof;
            default:         frame_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames  <= '0;
            stat_drops   <= '0;
            stat_data_dw <= '0;
        end else begin
            if (frame_done)
                stat_frames <= stat_frames + 16'd1;
            if (rx_err)
                stat_drops <= stat_drops + 16'd1;
            if (state == ST_DATA && fifo_rd_en)
                stat_data_dw <= stat_data_dw + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rxll_fis_dispatch.sv
// Scoreboard bench for rxll_fis_dispatch: a queue-backed FWFT FIFO model feeds
// frames; DMA beats and error pulses are collected and compared per scenario.
module tb_rxll_fis_dispatch;
    import ahci_fis_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] fifo_do;
    logic        fifo_empty;
    logic        fifo_eof_rdy;
    logic        fifo_rd_en;
    logic [31:0] dma_data;
    logic        dma_valid;
    logic        dma_last;
    logic        dma_ready;
    logic        reg_fis_vld;
    logic [7:0]  reg_fis_type;
    logic [2:0]  reg_fis_len;
    logic [2:0]  reg_addr;
    logic [31:0] reg_dout;
    logic        reg_fis_ack;
    logic        rx_err;
    logic [1:0]  rx_err_code;
    logic        busy;
`ifdef RXLL_DISPATCH_STATS_EN
    logic [15:0] stat_frames, stat_drops;
    logic [31:0] stat_data_dw;
`endif

    int passed = 0;
    int total  = 0;

    logic [35:0] fq[$];
    logic [32:0] exp_beats[$];
    logic [32:0] obs_beats[$];
    logic [1:0]  exp_errs[$];
    logic [1:0]  obs_errs[$];
    int pops = 0;
    int empty_pops = 0;
    int noready_pops = 0;

    always #5 clk = ~clk;

    rxll_fis_dispatch dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_do      (fifo_do),
        .fifo_empty   (fifo_empty),
        .fifo_eof_rdy (fifo_eof_rdy),
        .fifo_rd_en   (fifo_rd_en),
        .dma_data     (dma_data),
        .dma_valid    (dma_valid),
        .dma_last     (dma_last),
        .dma_ready    (dma_ready),
        .reg_fis_vld  (reg_fis_vld),
        .reg_fis_type (reg_fis_type),
        .reg_fis_len  (reg_fis_len),
        .reg_addr     (reg_addr),
        .reg_dout     (reg_dout),
        .reg_fis_ack  (reg_fis_ack),
        .rx_err       (rx_err),
        .rx_err_code  (rx_err_code),
        .busy         (busy)
`ifdef RXLL_DISPATCH_STATS_EN
        ,
        .stat_frames  (stat_frames),
        .stat_drops   (stat_drops),
        .stat_data_dw (stat_data_dw)
`endif
    );

    // FIFO model plus output monitor: observe at negedge, pop/refresh just after posedge.
    always begin
        bit do_pop;
        bit any_eof;
        @(negedge clk);
        if (!rst) begin
            if (fifo_rd_en && fifo_empty) empty_pops++;
            if (fifo_rd_en && dma_valid && !dma_ready) noready_pops++;
            if (dma_valid && dma_ready) obs_beats.push_back({dma_last, dma_data});
            if (rx_err) obs_errs.push_back(rx_err_code);
        end
        do_pop = fifo_rd_en && !rst;
        @(posedge clk);
        #1;
        if (rst)
            fq.delete();
        else if (do_pop && fq.size() > 0) begin
            void'(fq.pop_front());
            pops++;
        end
        any_eof = 1'b0;
        foreach (fq[i]) if (fq[i][LL_EOF]) any_eof = 1'b1;
        fifo_empty   = (fq.size() == 0);
        fifo_do      = (fq.size() == 0) ? 36'd0 : fq[0];
        fifo_eof_rdy = any_eof;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [35:0] mk(input logic [31:0] d, input logic eof, input logic err);
        return {err, eof, 2'b00, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_sb();
        exp_beats.delete();
        obs_beats.delete();
        exp_errs.delete();
        obs_errs.delete();
        pops = 0;
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (fq.size() == 0 && !busy) begin
                to = 1'b0;
                break;
            end
        end
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else passed++;
        total++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b exp 0", fifo_rd_en); else passed++;
        total++; if (dma_valid !== 1'b0) $display("FAIL reset_dma_valid: got %b exp 0", dma_valid); else passed++;
        total++; if (rx_err !== 1'b0 || rx_err_code !== 2'd0) $display("FAIL reset_rx_err: got %b/%0d exp 0/0", rx_err, rx_err_code); else passed++;
        total++; if (reg_fis_vld !== 1'b0 || reg_fis_len !== 3'd0 || reg_fis_type !== 8'h00)
            $display("FAIL reset_reg: got vld %b len %0d type %h exp 0 0 00", reg_fis_vld, reg_fis_len, reg_fis_type); else passed++;
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reg_capture();
        bit to;
        logic [31:0] dw[5];
        clear_sb();
        for (int i = 0; i < 5; i++) dw[i] = (i == 0) ? 32'h00AB_CD34 : 32'h1111_0000 + 32'(i);
        for (int i = 0; i < 5; i++) fq.push_back(mk(dw[i], i == 4, 1'b0));
        wait_idle(to);
        total++; if (to) $display("FAIL reg_timeout: frame not consumed"); else passed++;
        total++; if (reg_fis_vld !== 1'b1) $display("FAIL reg_vld: got %b exp 1", reg_fis_vld); else passed++;
        total++; if (reg_fis_type !== 8'h34) $display("FAIL reg_type: got %h exp 34", reg_fis_type); else passed++;
        total++; if (reg_fis_len !== 3'd5) $display("FAIL reg_len: got %0d exp 5", reg_fis_len); else passed++;
        reg_addr = 3'd4; #1;
        total++; if (reg_dout !== dw[4]) $display("FAIL reg_dout4: got %h exp %h", reg_dout, dw[4]); else passed++;
        reg_addr = 3'd0; #1;
        total++; if (reg_dout !== dw[0]) $display("FAIL reg_dout0: got %h exp %h", reg_dout, dw[0]); else passed++;
        total++; if (obs_beats.size() != 0 || pops != 5) $display("FAIL reg_traffic: beats %0d pops %0d exp 0 5", obs_beats.size(), pops); else passed++;
        reg_fis_ack = 1'b1;
        tick(1);
        reg_fis_ack = 1'b0;
        total++; if (reg_fis_vld !== 1'b0) $display("FAIL reg_ack: got vld %b exp 0", reg_fis_vld); else passed++;
    endtask

    task automatic test_data_stream();
        bit to;
        int pat[6];
        pat = '{1, 0, 1, 1, 0, 1};
        clear_sb();
        noready_pops = 0;
        fq.push_back(mk({24'h0000AA, FIS_DATA}, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            fq.push_back(mk(32'hD000_0000 + 32'(i), i == 3, 1'b0));
            exp_beats.push_back({i == 3, 32'hD000_0000 + 32'(i)});
        end
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            dma_ready = (pat[i % 6] != 0);
            tick(1);
            if (fq.size() == 0 && !busy) begin
                to = 1'b0;
                break;
            end
        end
        dma_ready = 1'b1;
        tick(2);
        total++; if (to) $display("FAIL data_timeout: frame not consumed"); else passed++;
        total++; if (obs_beats.size() != exp_beats.size())
            $display("FAIL data_beats: got %0d exp %0d", obs_beats.size(), exp_beats.size()); else passed++;
        while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
            logic [32:0] e, o;
            e = exp_beats.pop_front();
            o = obs_beats.pop_front();
            total++; if (o !== e) $display("FAIL data_beat: got last %b data %h exp last %b data %h", o[32], o[31:0], e[32], e[31:0]); else passed++;
        end
        total++; if (pops != 5) $display("FAIL data_pops: got %0d exp 5", pops); else passed++;
        total++; if (noready_pops != 0) $display("FAIL data_noready: got %0d pops with ready low exp 0", noready_pops); else passed++;
        total++; if (obs_errs.size() != 0) $display("FAIL data_err: got %0d error pulses exp 0", obs_errs.size()); else passed++;
    endtask

    task automatic test_data_empty();
        bit to;
        clear_sb();
        fq.push_back(mk({24'h000000, FIS_DATA}, 1'b1, 1'b0));
        exp_errs.push_back(2'd0);
        wait_idle(to);
        total++; if (to) $display("FAIL dempty_timeout: frame not consumed"); else passed++;
        total++; if (obs_errs.size() != 1 || obs_errs[0] !== exp_errs[0])
            $display("FAIL dempty_err: got %0d pulses first code %0d exp 1 pulse code 0", obs_errs.size(), (obs_errs.size() > 0) ? obs_errs[0] : 2'd3); else passed++;
        total++; if (pops != 1 || obs_beats.size() != 0) $display("FAIL dempty_traffic: pops %0d beats %0d exp 1 0", pops, obs_beats.size()); else passed++;
    endtask

    task automatic test_data_linkerr();
        bit to;
        clear_sb();
        fq.push_back(mk({24'h000001, FIS_DATA}, 1'b0, 1'b0));
        fq.push_back(mk(32'hE000_0000, 1'b0, 1'b0));
        fq.push_back(mk(32'hE000_0001, 1'b0, 1'b1));
        fq.push_back(mk(32'h0000_0099, 1'b1, 1'b0));
        exp_beats.push_back({1'b0, 32'hE000_0000});
        exp_beats.push_back({1'b1, 32'hE000_0001});
        exp_errs.push_back(2'd1);
        exp_errs.push_back(2'd0);
        wait_idle(to);
        total++; if (to) $display("FAIL lerr_timeout: frames not consumed"); else passed++;
        total++; if (obs_beats.size() != 2) $display("FAIL lerr_beats: got %0d exp 2", obs_beats.size()); else passed++;
        while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
            logic [32:0] e, o;
            e = exp_beats.pop_front();
            o = obs_beats.pop_front();
            total++; if (o !== e) $display("FAIL lerr_beat: got last %b data %h exp last %b data %h", o[32], o[31:0], e[32], e[31:0]); else passed++;
        end
        total++; if (obs_errs.size() != exp_errs.size()) $display("FAIL lerr_errcount: got %0d exp %0d", obs_errs.size(), exp_errs.size()); else passed++;
        while (exp_errs.size() > 0 && obs_errs.size() > 0) begin
            logic [1:0] e, o;
            e = exp_errs.pop_front();
            o = obs_errs.pop_front();
            total++; if (o !== e) $display("FAIL lerr_code: got %0d exp %0d", o, e); else passed++;
        end
        total++; if (pops != 4) $display("FAIL lerr_pops: got %0d exp 4", pops); else passed++;
    endtask

    task automatic test_unknown();
        bit to;
        clear_sb();
        fq.push_back(mk(32'h0000_0099, 1'b0, 1'b0));
        fq.push_back(mk(32'h1234_5678, 1'b0, 1'b0));
        fq.push_back(mk(32'h9ABC_DEF0, 1'b1, 1'b0));
        exp_errs.push_back(2'd0);
        wait_idle(to);
        total++; if (to) $display("FAIL unk_timeout: frame not consumed"); else passed++;
        total++; if (obs_errs.size() != 1 || obs_errs[0] !== exp_errs[0])
            $display("FAIL unk_err: got %0d pulses first code %0d exp 1 pulse code 0", obs_errs.size(), (obs_errs.size() > 0) ? obs_errs[0] : 2'd3); else passed++;
        total++; if (pops != 3) $display("FAIL unk_pops: got %0d exp 3", pops); else passed++;
        total++; if (busy !== 1'b0 || rx_err !== 1'b0 || dma_valid !== 1'b0 || reg_fis_vld !== 1'b0 || obs_beats.size() != 0)
            $display("FAIL unk_idle: busy %b rx_err %b dma_valid %b vld %b beats %0d exp all 0", busy, rx_err, dma_valid, reg_fis_vld, obs_beats.size()); else passed++;
    endtask

    task automatic test_oversize();
        bit to;
        clear_sb();
        for (int i = 0; i < 9; i++)
            fq.push_back(mk((i == 0) ? {24'h000000, FIS_SDB} : 32'h5500_0000 + 32'(i), i == 8, 1'b0));
        exp_errs.push_back(2'd2);
        wait_idle(to);
        total++; if (to) $display("FAIL ovs_timeout: frame not consumed"); else passed++;
        total++; if (obs_errs.size() != 1 || obs_errs[0] !== exp_errs[0])
            $display("FAIL ovs_err: got %0d pulses first code %0d exp 1 pulse code 2", obs_errs.size(), (obs_errs.size() > 0) ? obs_errs[0] : 2'd3); else passed++;
        total++; if (pops != 9) $display("FAIL ovs_pops: got %0d exp 9", pops); else passed++;
        total++; if (reg_fis_vld !== 1'b0) $display("FAIL ovs_vld: got %b exp 0", reg_fis_vld); else passed++;
    endtask

    task automatic test_reg_stall();
        bit to;
        clear_sb();
        fq.push_back(mk({24'h000001, FIS_REG_D2H}, 1'b0, 1'b0));
        fq.push_back(mk(32'hA0A0_0001, 1'b0, 1'b0));
        fq.push_back(mk(32'hA0A0_0002, 1'b1, 1'b0));
        wait_idle(to);
        total++; if (to || reg_fis_vld !== 1'b1 || reg_fis_len !== 3'd3)
            $display("FAIL stall_first: timeout %b vld %b len %0d exp 0 1 3", to, reg_fis_vld, reg_fis_len); else passed++;
        pops = 0;
        fq.push_back(mk({24'h000002, FIS_PIO_SETUP}, 1'b0, 1'b0));
        fq.push_back(mk(32'hB0B0_0001, 1'b0, 1'b0));
        fq.push_back(mk(32'hB0B0_0002, 1'b0, 1'b0));
        fq.push_back(mk(32'hB0B0_0003, 1'b1, 1'b0));
        tick(10);
        total++; if (pops != 0 || fq.size() != 4) $display("FAIL stall_nopop: pops %0d left %0d exp 0 4", pops, fq.size()); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL stall_busy: got %b exp 1", busy); else passed++;
        total++; if (reg_fis_type !== 8'h34) $display("FAIL stall_hold: got type %h exp 34", reg_fis_type); else passed++;
        reg_fis_ack = 1'b1;
        tick(1);
        reg_fis_ack = 1'b0;
        wait_idle(to);
        total++; if (to) $display("FAIL stall_timeout: second frame not consumed"); else passed++;
        total++; if (reg_fis_vld !== 1'b1 || reg_fis_type !== 8'h5F || reg_fis_len !== 3'd4)
            $display("FAIL stall_second: vld %b type %h len %0d exp 1 5f 4", reg_fis_vld, reg_fis_type, reg_fis_len); else passed++;
        reg_addr = 3'd3; #1;
        total++; if (reg_dout !== 32'hB0B0_0003) $display("FAIL stall_dout: got %h exp b0b00003", reg_dout); else passed++;
        total++; if (pops != 4) $display("FAIL stall_pops: got %0d exp 4", pops); else passed++;
        reg_fis_ack = 1'b1;
        tick(1);
        reg_fis_ack = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_sb();
        dma_ready = 1'b1;
        fq.push_back(mk({24'h000003, FIS_DATA}, 1'b0, 1'b0));
        for (int i = 0; i < 6; i++) begin
            fq.push_back(mk(32'hC000_0000 + 32'(i), i == 5, 1'b0));
            if (i < 2) exp_beats.push_back({1'b0, 32'hC000_0000 + 32'(i)});
        end
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (obs_beats.size() >= 2) begin
                to = 1'b0;
                break;
            end
        end
        total++; if (to) $display("FAIL rstmid_timeout: two beats not seen"); else passed++;
        dma_ready = 1'b0;
        rst = 1'b1;
        tick(1);
        total++; if (busy !== 1'b0 || dma_valid !== 1'b0 || fifo_rd_en !== 1'b0)
            $display("FAIL rstmid_idle: busy %b dma_valid %b rd_en %b exp 0 0 0", busy, dma_valid, fifo_rd_en); else passed++;
        rst = 1'b0;
        dma_ready = 1'b1;
        tick(3);
        total++; if (obs_beats.size() != 2) $display("FAIL rstmid_beats: got %0d exp 2", obs_beats.size()); else passed++;
        while (exp_beats.size() > 0 && obs_beats.size() > 0) begin
            logic [32:0] e, o;
            e = exp_beats.pop_front();
            o = obs_beats.pop_front();
            total++; if (o !== e) $display("FAIL rstmid_beat: got last %b data %h exp last %b data %h", o[32], o[31:0], e[32], e[31:0]); else passed++;
        end
        total++; if (busy !== 1'b0 || rx_err !== 1'b0) $display("FAIL rstmid_after: busy %b rx_err %b exp 0 0", busy, rx_err); else passed++;
        total++; if (empty_pops != 0) $display("FAIL empty_pop: got %0d pops on empty exp 0", empty_pops); else passed++;
    endtask

    initial begin
        rst         = 1'b1;
        dma_ready   = 1'b1;
        reg_addr    = 3'd0;
        reg_fis_ack = 1'b0;
        test_reset();
        test_reg_capture();
        test_data_stream();
        test_data_empty();
        test_data_linkerr();
        test_unknown();
        test_oversize();
        test_reg_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
